// File: rtl/aes_encryption_core_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_encryption_core_if
// Description : FIFO handshake, key-store and result bus of the AES-128 core.
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_encryption_core_if;
    logic         read_fifo;
    logic         is_full;
    logic [127:0] fifo_in;
    logic [127:0] round_key_input;
    logic [127:0] round_key_0;
    logic [4:0]   round_key_addr;
    logic [127:0] data_output;
    logic         data_done;
    logic         data_valid;

    // master: surrounding FIFOs and key store; slave: the encryption core
    modport master (
        output read_fifo, is_full, fifo_in, round_key_input, round_key_0,
        input  round_key_addr, data_output, data_done, data_valid
    );
    modport slave (
        input  read_fifo, is_full, fifo_in, round_key_input, round_key_0,
        output round_key_addr, data_output, data_done, data_valid
    );
endinterface
`default_nettype wire

// File: rtl/aes_encryption_core.sv
`default_nettype none
// ============================================================================
// Module      : aes_encryption_core
// Description : Iterative AES-128 encryptor, one round per clock, external keys.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_encryption_core #(
    parameter int NUM_ROUNDS = 10
) (
    input  wire logic             clk,
    input  wire logic             n_rst,
    aes_encryption_core_if.slave  bus
);
    localparam logic [3:0] c_last_round = 4'(NUM_ROUNDS);

    // FIPS-197 S-box, entry 0x00 in the most significant byte
    localparam logic [2047:0] c_sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_ROUND = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t       r_fsm, w_fsm_next;
    logic [127:0] r_state, w_state_next;
    logic [127:0] r_dout, w_dout_next;
    logic [127:0] w_round_out;
    logic [3:0]   r_round, w_round_next;
    logic [3:0]   r_addr, w_addr_next;
    logic         r_done, w_done_next;
    logic         r_valid, w_valid_next;
    logic [7:0]   w_sb [16];
    logic [7:0]   w_sr [16];
    logic [7:0]   w_mc [16];

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // State byte i sits at [127-8i -: 8]; i = row + 4*column
    for (genvar i = 0; i < 16; i++) begin : g_sbox
        assign w_sb[i] = c_sbox[{~r_state[127-8*i -: 8], 3'b000} +: 8];
        assign w_sr[i] = w_sb[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
    end

    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign w_mc[4*c+0] = xtime(w_sr[4*c+0]) ^ xtime(w_sr[4*c+1]) ^ w_sr[4*c+1]
                           ^ w_sr[4*c+2] ^ w_sr[4*c+3];
        assign w_mc[4*c+1] = w_sr[4*c+0] ^ xtime(w_sr[4*c+1]) ^ xtime(w_sr[4*c+2])
                           ^ w_sr[4*c+2] ^ w_sr[4*c+3];
        assign w_mc[4*c+2] = w_sr[4*c+0] ^ w_sr[4*c+1] ^ xtime(w_sr[4*c+2])
                           ^ xtime(w_sr[4*c+3]) ^ w_sr[4*c+3];
        assign w_mc[4*c+3] = xtime(w_sr[4*c+0]) ^ w_sr[4*c+0] ^ w_sr[4*c+1]
                           ^ w_sr[4*c+2] ^ xtime(w_sr[4*c+3]);
    end

    for (genvar i = 0; i < 16; i++) begin : g_addkey
        assign w_round_out[127-8*i -: 8] = ((r_round == c_last_round) ? w_sr[i] : w_mc[i])
                                         ^ bus.round_key_input[127-8*i -: 8];
    end

    assign bus.round_key_addr = {1'b0, r_addr};
    assign bus.data_output    = r_dout;
    assign bus.data_done      = r_done;
    assign bus.data_valid     = r_valid;

    always_comb begin
        w_fsm_next   = r_fsm;
        w_state_next = r_state;
        w_dout_next  = r_dout;
        w_round_next = r_round;
        w_addr_next  = r_addr;
        w_done_next  = 1'b0;
        w_valid_next = r_valid;
        case (r_fsm)
            S_IDLE: begin
                if (bus.read_fifo) begin
                    w_state_next = bus.fifo_in ^ bus.round_key_0;
                    w_addr_next  = 4'd0;
                    w_valid_next = 1'b0;
                    w_fsm_next   = S_PRIME;
                end
            end
            S_PRIME: begin
                w_addr_next  = 4'd1;
                w_round_next = 4'd1;
                w_fsm_next   = S_ROUND;
            end
            S_ROUND: begin
                // The key store lags one cycle, so the address runs one ahead of the round
                if (r_addr < c_last_round) begin
                    w_addr_next = r_addr + 4'd1;
                end
                if (r_round < c_last_round) begin
                    w_state_next = w_round_out;
                    w_round_next = r_round + 4'd1;
                end else if (!bus.is_full) begin
                    w_dout_next  = w_round_out;
                    w_done_next  = 1'b1;
                    w_valid_next = 1'b1;
                    w_fsm_next   = S_IDLE;
                end else begin
                    w_state_next = w_round_out;
                    w_fsm_next   = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!bus.is_full) begin
                    w_dout_next  = r_state;
                    w_done_next  = 1'b1;
                    w_valid_next = 1'b1;
                    w_fsm_next   = S_IDLE;
                end
            end
            default: w_fsm_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_fsm   <= S_IDLE;
            r_state <= '0;
            r_dout  <= '0;
            r_round <= '0;
            r_addr  <= '0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_fsm   <= w_fsm_next;
            r_state <= w_state_next;
            r_dout  <= w_dout_next;
            r_round <= w_round_next;
            r_addr  <= w_addr_next;
            r_done  <= w_done_next;
            r_valid <= w_valid_next;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_aes_encryption_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_encryption_core
// Description : Directed and known-answer bench for aes_encryption_core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_encryption_core;
    localparam logic [2047:0] c_sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic         tb_clk = 1'b0;
    logic         tb_n_rst;
    int           checks = 0;
    int           failures = 0;
    logic [127:0] rk [11];
    logic [127:0] ks [16];

    aes_encryption_core_if bus ();

    aes_encryption_core #(.NUM_ROUNDS(10)) dut (
        .clk   (tb_clk),
        .n_rst (tb_n_rst),
        .bus   (bus)
    );

    always #5 tb_clk = ~tb_clk;

    // Registered key store: entry n holds round key n+1
    always @(posedge tb_clk) bus.round_key_input <= ks[bus.round_key_addr[3:0]];

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    function automatic logic [7:0] sb(input logic [7:0] b);
        return c_sbox[2047 - 8*b -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return b[7] ? ((b << 1) ^ 8'h1b) : (b << 1);
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rcon [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                   8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0)
                tmp = {sb(tmp[23:16]), sb(tmp[15:8]), sb(tmp[7:0]), sb(tmp[31:24])}
                    ^ {rcon[i/4-1], 24'h0};
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        for (int n = 0; n < 16; n++) ks[n] = (n < 10) ? rk[n+1] : 128'h0;
        bus.round_key_0 = rk[0];
    endtask

    function automatic logic [127:0] aes_model(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] out;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb(s[(i%4) + 4*(((i/4) + (i%4)) % 4)]);
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++)
                    s[4*c+j] = (r < 10) ? (xt(t[4*c+j]) ^ xt(t[4*c+(j+1)%4]) ^ t[4*c+(j+1)%4]
                                           ^ t[4*c+(j+2)%4] ^ t[4*c+(j+3)%4])
                                        : t[4*c+j];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[r][127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
        return out;
    endfunction

    // Accepts one block and waits (bounded) for data_done; lat = -1 on timeout
    task automatic run_block(input logic [127:0] pt, output logic [127:0] ct, output int lat);
        bus.fifo_in   = pt;
        bus.read_fifo = 1'b1;
        tick();
        bus.read_fifo = 1'b0;
        lat = -1;
        ct  = '0;
        for (int k = 0; k < 40; k++) begin
            if (bus.data_done === 1'b1) begin
                lat = k;
                ct  = bus.data_output;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        tb_n_rst = 1'b0;
        repeat (3) tick();
        checks++; if (bus.data_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.data_done); end
        checks++; if (bus.data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.data_valid); end
        checks++; if (bus.data_output !== 128'h0) begin failures++; $display("FAIL reset_dout got=%h exp=0", bus.data_output); end
        checks++; if (bus.round_key_addr !== 5'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", bus.round_key_addr); end
        tb_n_rst = 1'b1;
        tick();
    endtask

    task automatic test_fips_c1();
        expand_key(128'h000102030405060708090a0b0c0d0e0f);
        bus.fifo_in   = 128'h00112233445566778899aabbccddeeff;
        bus.read_fifo = 1'b1;
        tick();
        bus.read_fifo = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            checks++; if (bus.round_key_addr !== 5'(k)) begin failures++; $display("FAIL c1_addr cycle=%0d got=%0d exp=%0d", k, bus.round_key_addr, k); end
            checks++; if (bus.data_done !== 1'b0) begin failures++; $display("FAIL c1_early_done cycle=%0d got=%b exp=0", k, bus.data_done); end
            tick();
        end
        checks++; if (bus.data_done !== 1'b1) begin failures++; $display("FAIL c1_done_at_11 got=%b exp=1", bus.data_done); end
        checks++; if (bus.data_output !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin failures++; $display("FAIL c1_ct got=%h exp=69c4e0d86a7b0430d8cdb78070b4c55a", bus.data_output); end
        checks++; if (bus.data_valid !== 1'b1) begin failures++; $display("FAIL c1_valid got=%b exp=1", bus.data_valid); end
        checks++; if (bus.round_key_addr !== 5'd10) begin failures++; $display("FAIL c1_addr_hold got=%0d exp=10", bus.round_key_addr); end
        tick();
        checks++; if (bus.data_done !== 1'b0) begin failures++; $display("FAIL c1_done_pulse got=%b exp=0", bus.data_done); end
        checks++; if (bus.data_valid !== 1'b1 || bus.data_output !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
            failures++; $display("FAIL c1_hold_result valid=%b dout=%h exp valid=1 dout=69c4e0d86a7b0430d8cdb78070b4c55a", bus.data_valid, bus.data_output);
        end
    endtask

    task automatic test_fips_b();
        logic [127:0] ct;
        int           lat;
        expand_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
        run_block(128'h3243f6a8885a308d313198a2e0370734, ct, lat);
        checks++; if (lat !== 11) begin failures++; $display("FAIL b_latency got=%0d exp=11", lat); end
        checks++; if (ct !== 128'h3925841d02dc09fbdc118597196a0b32) begin failures++; $display("FAIL b_ct got=%h exp=3925841d02dc09fbdc118597196a0b32", ct); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] pt, ct;
        int           lat;
        for (int n = 0; n < 500; n++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            run_block(pt, ct, lat);
            checks++; if (lat !== 11) begin failures++; $display("FAIL b2b_latency blk=%0d got=%0d exp=11", n, lat); end
            checks++; if (ct !== aes_model(pt)) begin failures++; $display("FAIL b2b_ct blk=%0d got=%h exp=%h", n, ct, aes_model(pt)); end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] pt = 128'h00112233445566778899aabbccddeeff;
        int           early = 0;
        bus.fifo_in   = pt;
        bus.read_fifo = 1'b1;
        tick();
        bus.read_fifo = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (k == 5) bus.is_full = 1'b1;
            if (bus.data_done !== 1'b0) early++;
            tick();
        end
        checks++; if (early != 0) begin failures++; $display("FAIL bp_early_done got=%0d exp=0", early); end
        checks++; if (bus.data_valid !== 1'b0) begin failures++; $display("FAIL bp_valid_in_hold got=%b exp=0", bus.data_valid); end
        bus.is_full = 1'b0;
        tick();
        checks++; if (bus.data_done !== 1'b1) begin failures++; $display("FAIL bp_done got=%b exp=1", bus.data_done); end
        checks++; if (bus.data_output !== aes_model(pt)) begin failures++; $display("FAIL bp_ct got=%h exp=%h", bus.data_output, aes_model(pt)); end
        tick();
        checks++; if (bus.data_done !== 1'b0) begin failures++; $display("FAIL bp_single_pulse got=%b exp=0", bus.data_done); end
    endtask

    task automatic test_ignore_read();
        logic [127:0] pt = 128'hdeadbeef0123456789abcdeffedcba98;
        logic [127:0] ct = '0;
        int           pulses = 0;
        int           at = -1;
        bus.fifo_in   = pt;
        bus.read_fifo = 1'b1;
        tick();
        bus.read_fifo = 1'b0;
        for (int k = 0; k < 30; k++) begin
            bus.read_fifo = (k == 3 || k == 7);
            bus.fifo_in   = (k == 3 || k == 7) ? ~pt : pt;
            if (bus.data_done === 1'b1) begin pulses++; at = k; ct = bus.data_output; end
            tick();
        end
        bus.read_fifo = 1'b0;
        checks++; if (pulses != 1) begin failures++; $display("FAIL ign_pulses got=%0d exp=1", pulses); end
        checks++; if (at != 11) begin failures++; $display("FAIL ign_done_cycle got=%0d exp=11", at); end
        checks++; if (ct !== aes_model(pt)) begin failures++; $display("FAIL ign_ct got=%h exp=%h", ct, aes_model(pt)); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] pt = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        logic [127:0] ct;
        int           lat;
        int           stray = 0;
        bus.fifo_in   = pt;
        bus.read_fifo = 1'b1;
        tick();
        bus.read_fifo = 1'b0;
        repeat (5) tick();
        tb_n_rst = 1'b0;
        tick();
        tb_n_rst = 1'b1;
        checks++; if (bus.data_done !== 1'b0) begin failures++; $display("FAIL rmid_done got=%b exp=0", bus.data_done); end
        checks++; if (bus.data_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", bus.data_valid); end
        checks++; if (bus.data_output !== 128'h0) begin failures++; $display("FAIL rmid_dout got=%h exp=0", bus.data_output); end
        checks++; if (bus.round_key_addr !== 5'd0) begin failures++; $display("FAIL rmid_addr got=%0d exp=0", bus.round_key_addr); end
        for (int k = 0; k < 15; k++) begin
            if (bus.data_done !== 1'b0) stray++;
            tick();
        end
        checks++; if (stray != 0) begin failures++; $display("FAIL rmid_stray_done got=%0d exp=0", stray); end
        run_block(~pt, ct, lat);
        checks++; if (lat !== 11) begin failures++; $display("FAIL rmid_next_latency got=%0d exp=11", lat); end
        checks++; if (ct !== aes_model(~pt)) begin failures++; $display("FAIL rmid_next_ct got=%h exp=%h", ct, aes_model(~pt)); end
    endtask

    initial begin
        tb_n_rst          = 1'b0;
        bus.read_fifo     = 1'b0;
        bus.is_full       = 1'b0;
        bus.fifo_in       = '0;
        bus.round_key_0   = '0;
        for (int n = 0; n < 16; n++) ks[n] = '0;
        test_reset();
        test_fips_c1();
        test_fips_b();
        test_back_to_back();
        test_backpressure();
        test_ignore_read();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/aes_encryption_core.md
Name: aes_encryption_core

Overview:
- Iterative AES-128 encryption datapath. Encrypts one 128-bit block per request, one round per clock.
- Round keys are precomputed elsewhere:
  - round key 0 arrives on a dedicated port;
  - round keys 1..10 are fetched from an external registered key store, addressed by this block.
- Sits between an input FIFO (read handshake) and an output FIFO (full back-pressure).

Parameters:
- NUM_ROUNDS, 10, number of AES rounds; fixed for AES-128.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- n_rst  input  1  synchronous active-low reset, sampled on rising clk.
- read_fifo  input  1  start strobe; input FIFO presents a block on fifo_in this cycle.
- is_full  input  1  downstream FIFO full; block must not complete while high.
- fifo_in  input  128  plaintext; [127:120] is state byte 0 (FIPS-197 column-major order).
- round_key_input  input  128  round key from the external key store. It is a register updated at each clk edge with entry round_key_addr[3:0], giving one cycle of latency. Entry n holds round key n+1.
- round_key_0  input  128  initial (whitening) round key, static during operation.
- round_key_addr  output  5  registered key-store address; bit 4 is always 0.
- data_output  output  128  ciphertext, same byte order as fifo_in.
- data_done  output  1  one-cycle pulse: ciphertext completed this cycle.
- data_valid  output  1  level: data_output holds a valid ciphertext.

Behaviour:
- Reset (n_rst low at an edge): FSM to IDLE; data_output, round counter and round_key_addr to 0; data_done and data_valid to 0. Reset mid-operation aborts the block with no output.
- FSM states: IDLE, PRIME, ROUND, HOLD.
- IDLE:
  - On an edge with read_fifo=1: state <= fifo_in XOR round_key_0; round_key_addr <= 0; data_valid <= 0; go to PRIME.
  - read_fifo is ignored in every other state.
- PRIME: one bubble cycle while the key store fetches entry 0. round_key_addr <= 1; round <= 1; go to ROUND.
- ROUND r (r = 1..10):
  - round_key_input equals round key r.
  - r < 10: state <= MixColumns(ShiftRows(SubBytes(state))) XOR round_key_input; round_key_addr <= r+1 (never exceeds 10; held at 10 once reached).
  - r = 10: omit MixColumns. If is_full=0: data_output <= result; data_done <= 1 for exactly one cycle; data_valid <= 1; go to IDLE. If is_full=1: store result internally and go to HOLD.
- HOLD: stall while is_full=1. On the first edge with is_full=0, load data_output, pulse data_done, set data_valid, go to IDLE.
- Latency with no back-pressure: read_fifo sampled at edge E0 -> data_done high after edge E11 (11 cycles). data_done is 0 at every other time.
- data_valid stays high, and data_output stays stable, until the next accepted read_fifo or reset.
- Arithmetic:
  - SubBytes uses the standard FIPS-197 S-box as a 256-entry constant LUT, 16 parallel instances.
  - ShiftRows: row i rotated left by i bytes.
  - MixColumns: GF(2^8) with polynomial 0x11B (xtime = shift left, XOR 0x1B on carry), matrix [2 3 1 1] circulant.
- Back-to-back operation: read_fifo may be asserted the cycle after data_done; the new block is accepted on that edge.

Test Plan:
- FIPS-197 C.1 vector, keys 000102…0f expansion, is_full=0: fifo_in=00112233445566778899aabbccddeeff, pulse read_fifo for one cycle -> data_done pulses exactly 11 cycles later; data_output=69c4e0d86a7b0430d8cdb78070b4c55a; data_valid=1.
- Address sequence for the same block: round_key_addr reads 0,1,2,…,10 on successive cycles after acceptance, and is never greater than 10.
- FIPS-197 Appendix B (key 2b7e1516…4f3c, pt 3243f6a8885a308d313198a2e0370734) -> 3925841d02dc09fbdc118597196a0b32. Run 500 random blocks back-to-back against a software model -> all match.
- Back-pressure: hold is_full=1 from cycle 5 until cycle 20 -> no data_done until the first edge with is_full=0; then a single pulse with the correct ciphertext.
- read_fifo pulsed at cycles 3 and 7 of a block in progress -> ignored; the result is unaffected; only one data_done.
- n_rst low at round 5 -> the next cycle shows data_done=0, data_valid=0, data_output=0, round_key_addr=0. A following block encrypts correctly.
